// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative write-through data cache:
// controller state encoding, geometry constants and address slicing helpers.
// All index/tag math works on the offset from the data-memory base address.
package cache_pkg;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int unsigned SETS      = 64;
  localparam int unsigned INDEX_W   = 6;
  localparam int unsigned TAG_W     = 9;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LINE_W    = 2 * WORD_W;

  localparam int unsigned WORD_SEL_LSB = 2;
  localparam int unsigned INDEX_LSB    = 3;
  localparam int unsigned TAG_LSB      = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    StIdle,
    StFill0,
    StFill1,
    StWrite
  } state_e;

  // Set index: off[8:3]
  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return INDEX_W'((addr - BASE_ADDR) >> INDEX_LSB);
  endfunction

  // Tag: off[17:9]
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return TAG_W'((addr - BASE_ADDR) >> TAG_LSB);
  endfunction

  // Word within the 2-word line: off[2]
  function automatic logic addr_word_sel(input logic [31:0] addr);
    return 1'((addr - BASE_ADDR) >> WORD_SEL_LSB);
  endfunction

endpackage

// File: rtl/cache_ways.sv
// Storage for the two cache ways: valid/tag/data arrays per way plus one LRU
// bit per set (the LRU bit names the victim way). Lookup is combinational;
// line fill, word update and LRU touch all happen at the clock edge and all
// address the set selected by the lookup port. rst clears valid and LRU bits.
module cache_ways
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  lookup_index,
  input  logic [TAG_W-1:0]    lookup_tag,
  input  logic                lookup_word_sel,
  output logic                hit,
  output logic                hit_way,
  output logic [WORD_W-1:0]   hit_word,
  input  logic                touch_en,
  input  logic                fill_en,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                upd_en,
  input  logic [WORD_W-1:0]   upd_data
);

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] data_q  [2][SETS];

  logic              hit0;
  logic              hit1;
  logic              victim;
  logic [LINE_W-1:0] hit_line;

  // Tag compare in both ways; fills only happen on a miss so at most one matches
  always_comb begin
    hit0     = valid_q[0][lookup_index] && (tag_q[0][lookup_index] == lookup_tag);
    hit1     = valid_q[1][lookup_index] && (tag_q[1][lookup_index] == lookup_tag);
    hit      = hit0 | hit1;
    hit_way  = hit1;
    hit_line = hit1 ? data_q[1][lookup_index] : data_q[0][lookup_index];
    hit_word = lookup_word_sel ? hit_line[LINE_W-1:WORD_W] : hit_line[WORD_W-1:0];
    victim   = lru_q[lookup_index];
  end

  // Valid and LRU state; any access to way w makes the other way the victim
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (fill_en) begin
      valid_q[victim][lookup_index] <= 1'b1;
      lru_q[lookup_index]           <= ~victim;
    end else if (touch_en || upd_en) begin
      lru_q[lookup_index] <= ~hit_way;
    end
  end

  // Tag and data arrays need no reset; valid bits gate them
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[victim][lookup_index]  <= lookup_tag;
      data_q[victim][lookup_index] <= fill_line;
    end else if (upd_en) begin
      if (lookup_word_sel) begin
        data_q[hit_way][lookup_index][LINE_W-1:WORD_W] <= upd_data;
      end else begin
        data_q[hit_way][lookup_index][WORD_W-1:0] <= upd_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits complete in the request
// cycle; read misses fetch a 2-word line with two SRAM reads; writes always
// go to SRAM and update the cached word on a hit.
// Optional build macro CACHE_STATS_EN adds hit_count/miss_count outputs.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_e      state_q;
  logic [31:0] word0_q;
  logic        first_q;     // first cycle of an SRAM access: sram_ready is stale

  logic [31:0] lookup_addr;
  logic        accept;
  logic        rd_req;
  logic        hit;
  logic        hit_way;
  logic [31:0] hit_word;
  logic        touch_en;
  logic        fill_en;
  logic        write_done;
  logic        upd_en;

  // Outside IDLE the registered SRAM address holds the request being serviced
  assign lookup_addr = (state_q == StIdle) ? address : sram_address;
  assign accept      = sram_ready & ~first_q;
  assign rd_req      = mem_r_en & ~mem_w_en;
  assign touch_en    = (state_q == StIdle) & rd_req & hit;
  assign fill_en     = (state_q == StFill1) & accept;
  assign write_done  = (state_q == StWrite) & accept;
  assign upd_en      = write_done & hit;

  cache_ways u_ways (
    .clk             (clk),
    .rst             (rst),
    .lookup_index    (addr_index(lookup_addr)),
    .lookup_tag      (addr_tag(lookup_addr)),
    .lookup_word_sel (addr_word_sel(lookup_addr)),
    .hit             (hit),
    .hit_way         (hit_way),
    .hit_word        (hit_word),
    .touch_en        (touch_en),
    .fill_en         (fill_en),
    .fill_line       ({sram_rdata, word0_q}),
    .upd_en          (upd_en),
    .upd_data        (sram_wdata)
  );

  // Controller FSM with registered SRAM request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      word0_q      <= '0;
      first_q      <= 1'b0;
      sram_r_en    <= 1'b0;
      sram_w_en    <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
    end else begin
      first_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_w_en) begin
            state_q      <= StWrite;
            sram_w_en    <= 1'b1;
            sram_address <= address;
            sram_wdata   <= wdata;
            first_q      <= 1'b1;
          end else if (mem_r_en && !hit) begin
            state_q      <= StFill0;
            sram_r_en    <= 1'b1;
            sram_address <= {address[31:3], 3'b000};
            first_q      <= 1'b1;
          end
        end
        StFill0: begin
          if (accept) begin
            state_q      <= StFill1;
            word0_q      <= sram_rdata;
            sram_address <= {sram_address[31:3], 3'b100};
            first_q      <= 1'b1;
          end
        end
        StFill1: begin
          // Fill completes even if the request was dropped meanwhile
          if (accept) begin
            state_q   <= StIdle;
            sram_r_en <= 1'b0;
          end
        end
        StWrite: begin
          if (accept) begin
            state_q   <= StIdle;
            sram_w_en <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pipeline handshake and read data; the fill-completion cycle forwards SRAM data
  always_comb begin
    ready = 1'b0;
    rdata = hit_word;
    unique case (state_q)
      StIdle:  ready = ~mem_w_en & (~mem_r_en | hit);
      StFill0: ready = 1'b0;
      StFill1: begin
        ready = accept;
        rdata = addr_word_sel(address) ? sram_rdata : word0_q;
      end
      StWrite: ready = accept;
      default: ready = 1'b0;
    endcase
  end

`ifdef CACHE_STATS_EN
  // One count per completed request; writes are classified by their lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (touch_en || upd_en) begin
        hit_count <= hit_count + 32'd1;
      end
      if (fill_en || (write_done && !hit)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: behavioural SRAM controller model (reads
// complete on their 6th enabled cycle, writes on their 5th), a table of
// request vectors with expected data/latency/SRAM traffic, and hand-written
// sequences for reset state, fill addresses, dropped fill and mid-fill reset.
// Honours CACHE_STATS_EN when defined.
module tb_cache_controller;

  localparam int R_LAT = 6;
  localparam int W_LAT = 5;

  logic        clk;
  logic        rst;
  logic        mem_init;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks;
  int failures;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // SRAM controller model
  logic [31:0] sram_mem [0:1023];
  logic [31:0] rd_log [0:15];
  int          cnt;
  int          rd_cnt;
  int          wr_cnt;

  assign sram_ready = !(sram_r_en || sram_w_en) || (cnt == (sram_w_en ? W_LAT : R_LAT) - 1);
  assign sram_rdata = sram_mem[sram_address[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= pat(32'(i) << 2);
      rd_cnt <= 0;
      wr_cnt <= 0;
    end else begin
      if (sram_w_en && sram_ready) begin
        sram_mem[sram_address[11:2]] <= sram_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (sram_r_en && sram_ready) begin
        rd_log[rd_cnt[3:0]] <= sram_address;
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (rst || !(sram_r_en || sram_w_en) || sram_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raise one request, hold it until ready, report latency (cycle 0 = request cycle)
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic got);
    @(posedge clk);
    #1;
    mem_r_en = !wr;
    mem_w_en = wr;
    address  = addr;
    wdata    = wd;
    lat      = 0;
    got      = 1'b0;
    rd       = '0;
    while (lat < 100) begin
      @(negedge clk);
      if (ready) begin
        rd  = rdata;
        got = 1'b1;
        break;
      end
      lat++;
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vecs [14];

  initial begin : main
    int          lat;
    logic [31:0] rd;
    logic        got;
    int          r0;
    int          w0;
    int          n;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 32'd1024, 32'h0,         pat(32'd1024), 12, 2, 0};  // cold miss
    vecs[1]  = '{1'b0, 32'd1024, 32'h0,         pat(32'd1024), 0,  0, 0};
    vecs[2]  = '{1'b0, 32'd1028, 32'h0,         pat(32'd1028), 0,  0, 0};
    vecs[3]  = '{1'b0, 32'd1536, 32'h0,         pat(32'd1536), 12, 2, 0};  // set 0, way 1
    vecs[4]  = '{1'b0, 32'd2048, 32'h0,         pat(32'd2048), 12, 2, 0};  // evicts 1024
    vecs[5]  = '{1'b0, 32'd1536, 32'h0,         pat(32'd1536), 0,  0, 0};
    vecs[6]  = '{1'b0, 32'd1024, 32'h0,         pat(32'd1024), 12, 2, 0};  // evicts 2048
    vecs[7]  = '{1'b1, 32'd1024, 32'hDEADBEEF,  32'h0,         5,  0, 1};  // write hit
    vecs[8]  = '{1'b0, 32'd1024, 32'h0,         32'hDEADBEEF,  0,  0, 0};
    vecs[9]  = '{1'b1, 32'd1040, 32'h12345678,  32'h0,         5,  0, 1};  // write miss
    vecs[10] = '{1'b0, 32'd1040, 32'h0,         32'h12345678,  12, 2, 0};  // not allocated
    vecs[11] = '{1'b0, 32'd1044, 32'h0,         pat(32'd1044), 0,  0, 0};
    vecs[12] = '{1'b0, 32'd1536, 32'h0,         pat(32'd1536), 0,  0, 0};
    vecs[13] = '{1'b0, 32'd2048, 32'h0,         pat(32'd2048), 12, 2, 0};

    rst      = 1'b1;
    mem_init = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'd0;
    wdata    = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_init = 1'b0;

    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_sram_r_en", 32'(sram_r_en), 32'd0);
    check("reset_sram_w_en", 32'(sram_w_en), 32'd0);
`ifdef CACHE_STATS_EN
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
`endif

    for (int i = 0; i < 14; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, got);
      check($sformatf("vec%0d_done", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_sram_reads", i), 32'(rd_cnt - r0), 32'(vecs[i].exp_reads));
      check($sformatf("vec%0d_sram_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_writes));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
      if (i == 0) begin
        check("fill_addr_word0", rd_log[0], 32'd1024);
        check("fill_addr_word1", rd_log[1], 32'd1028);
      end
    end
    check("write_through_1024", sram_mem[256], 32'hDEADBEEF);

    // Request dropped mid-fill: the fill still completes and the line stays
    @(posedge clk);
    #1;
    mem_r_en = 1'b1;
    address  = 32'd1056;
    repeat (3) @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    address  = 32'd0;
    n = 0;
    while (sram_r_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drop_fill_finished", 32'(sram_r_en), 32'd0);
    do_req(1'b0, 32'd1056, 32'h0, lat, rd, got);
    check("drop_fill_hit_latency", 32'(lat), 32'd0);
    check("drop_fill_hit_rdata", rd, pat(32'd1056));
    do_req(1'b0, 32'd1060, 32'h0, lat, rd, got);
    check("drop_fill_word1_rdata", rd, pat(32'd1060));
`ifdef CACHE_STATS_EN
    check("stats_hits_before_rst", hit_count, 32'd9);
    check("stats_misses_before_rst", miss_count, 32'd8);
`endif

    // Reset during FILL0 of a miss on 2560 (set 0, new tag)
    @(posedge clk);
    #1;
    mem_r_en = 1'b1;
    address  = 32'd2560;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_fill0_r_en", 32'(sram_r_en), 32'd1);
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_sram_r_en_low", 32'(sram_r_en), 32'd0);
    check("rst_ready_idle", 32'(ready), 32'd1);
`ifdef CACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    do_req(1'b0, 32'd1024, 32'h0, lat, rd, got);
    check("post_rst_1024_latency", 32'(lat), 32'd12);
    check("post_rst_1024_rdata", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'd1536, 32'h0, lat, rd, got);
    check("post_rst_1536_latency", 32'(lat), 32'd12);
    do_req(1'b0, 32'd1024, 32'h0, lat, rd, got);
    check("post_rst_rehit_latency", 32'(lat), 32'd0);
    check("post_rst_rehit_rdata", rd, 32'hDEADBEEF);
`ifdef CACHE_STATS_EN
    check("post_rst_hit_count", hit_count, 32'd1);
    check("post_rst_miss_count", miss_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
